// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small word FIFO.
// Queued words go out back-to-back; parity mode and stop-bit count are parameters.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLK_FREQ    = 24000000,
  parameter int BAUD_RATE   = 8000000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0]    FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   ready_q, ready_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

  logic                   push;
  logic                   pop;
  logic                   bit_end;
  logic [DATA_BITS-1:0]   head;

  // Parity of a word as it will appear on the line (even or odd sense).
  function automatic logic parity_f(input logic [DATA_BITS-1:0] w);
    logic p;
    p = ^w;
    if (PARITY_MODE == 2) p = ~p;
    return p;
  endfunction

  assign head    = mem_q[rd_ptr_q];
  assign bit_end = (cnt_q == CNT_LAST);
  assign push    = data_valid && ready_q;

  // Next-state logic: frame sequencing, bit timing and FIFO bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
          shift_d = head;
          par_d   = parity_f(head);
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_MODE != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            // Chain straight into the next frame so there is no idle gap.
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = START;
              shift_d = head;
              par_d   = parity_f(head);
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (count_d != FULL);
  end

  // Control registers; reset aborts any frame and flushes the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Datapath registers: shifter, latched parity and FIFO storage.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
    if (push && !reset) mem_q[wr_ptr_q] <= data_in;
  end

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign data_ready = ready_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of uart_tx_fifo against a
// frame/queue level reference model.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 24000000;
  localparam int BAUD     = 8000000;
  localparam int DB       = 8;
  localparam int PM       = 1;
  localparam int SB       = 1;
  localparam int DEPTH    = 4;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FLEN     = 1 + DB + ((PM != 0) ? 1 : 0) + SB;
  localparam int FCLK     = FLEN * CPB;

  logic                        clk;
  logic                        reset;
  logic [DB-1:0]               data_in;
  logic                        data_valid;
  logic                        data_ready;
  logic                        tx;
  logic                        tx_busy;
  logic [$clog2(DEPTH):0]      fifo_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state: queued words, frame in flight and position in it.
  logic [DB-1:0] mq[$];
  bit            m_busy  = 1'b0;
  int            m_pos   = 0;
  logic [15:0]   m_frame = '1;
  bit            m_ready = 1'b1;

  uart_tx_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(DB),
    .PARITY_MODE(PM), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [15:0] make_frame(input logic [DB-1:0] w);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1 + i] = w[i];
    if (PM != 0) f[1 + DB] = (^w) ^ (PM == 2);
    return f;
  endfunction

  function automatic logic exp_tx();
    return m_busy ? m_frame[m_pos / CPB] : 1'b1;
  endfunction

  task automatic model_edge(input bit rst, input bit vld, input logic [DB-1:0] d);
    bit push;
    if (rst) begin
      mq.delete();
      m_busy  = 1'b0;
      m_pos   = 0;
      m_ready = 1'b1;
    end else begin
      push = vld && m_ready;
      if (!m_busy) begin
        if (mq.size() > 0) begin
          m_frame = make_frame(mq.pop_front());
          m_busy  = 1'b1;
          m_pos   = 0;
        end
      end else if (m_pos == FCLK - 1) begin
        if (mq.size() > 0) begin
          m_frame = make_frame(mq.pop_front());
          m_pos   = 0;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_pos++;
      end
      if (push) mq.push_back(d);
      m_ready = (mq.size() != DEPTH);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit vld, input logic [DB-1:0] d);
    reset      = rst;
    data_valid = vld;
    data_in    = d;
    @(posedge clk);
    model_edge(rst, vld, d);
    #1;
    check("tx", {31'd0, tx}, {31'd0, exp_tx()});
    check("tx_busy", {31'd0, tx_busy}, {31'd0, m_busy});
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("data_ready", {31'd0, data_ready}, {31'd0, m_ready});
  endtask

  logic [10:0]   exp_a5;
  logic [DB-1:0] w [6];
  logic          tx_log [40];
  int            busy_cnt, k, run, max_run, prev_cnt, low_cnt;
  bit            pre_ready, vld, saw_full, fb_done;

  initial begin
    reset = 1'b1; data_valid = 1'b0; data_in = '0;

    // Reset state
    step(1, 0, '0);
    step(1, 0, '0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_ready", {31'd0, data_ready}, 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    step(0, 0, '0);

    // Single 0xA5 frame, 8E1: start, A5 LSB first, parity 0, stop
    exp_a5 = {1'b1, 1'b0, 8'hA5, 1'b0};
    step(0, 1, 8'hA5);
    check("a5_pre_tx", {31'd0, tx}, 32'd1);
    busy_cnt = 0;
    for (int i = 0; i < 36; i++) begin
      step(0, 0, DB'($urandom));
      tx_log[i] = tx;
      if (tx_busy) busy_cnt++;
    end
    for (int i = 0; i < 33; i++) check("a5_bit", {31'd0, tx_log[i]}, {31'd0, exp_a5[i / 3]});
    check("a5_idle_after", {31'd0, tx_log[33]}, 32'd1);
    check("a5_busy_len", busy_cnt, 32'd33);

    // 0x07: three ones, even parity bit is 1
    step(0, 1, 8'h07);
    for (int i = 0; i < 36; i++) begin
      step(0, 0, DB'($urandom));
      tx_log[i] = tx;
    end
    check("p07_start", {31'd0, tx_log[1]}, 32'd0);
    check("p07_d3", {31'd0, tx_log[13]}, 32'd0);
    check("p07_parity", {31'd0, tx_log[28]}, 32'd1);
    check("p07_stop", {31'd0, tx_log[31]}, 32'd1);

    // Burst of 6 distinct words with data_valid held high
    begin
      logic [DB-1:0] base;
      base = DB'($urandom);
      for (int i = 0; i < 6; i++) w[i] = base + DB'(i * 37);
    end
    k = 0; run = 0; max_run = 0; saw_full = 0; fb_done = 0;
    prev_cnt = int'(fifo_count);
    for (int c = 0; c < 230; c++) begin
      vld = (k < 6);
      pre_ready = m_ready;
      step(0, vld, vld ? w[k] : DB'($urandom));
      if (vld && pre_ready) k++;
      if (tx_busy) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (fifo_count == 4 && !data_ready) saw_full = 1;
      if (!fb_done && prev_cnt == 4 && fifo_count == 3) begin
        fb_done = 1;
        check("fb_ready_rises", {31'd0, data_ready}, 32'd1);
        check("fb_word_refused", k, 32'd5);
      end
      prev_cnt = int'(fifo_count);
    end
    check("burst_full_seen", {31'd0, saw_full}, 32'd1);
    check("burst_fb_seen", {31'd0, fb_done}, 32'd1);
    check("burst_accepted", k, 32'd6);
    check("burst_busy_run", max_run, 32'd198);

    // Reset during bit 4 of a frame with two words queued
    step(0, 1, DB'($urandom));
    step(0, 1, DB'($urandom));
    step(0, 1, DB'($urandom));
    for (int i = 0; i < 40 && m_pos != 13; i++) step(0, 0, DB'($urandom));
    check("mid_count", 32'(fifo_count), 32'd2);
    check("mid_busy", {31'd0, tx_busy}, 32'd1);
    step(1, 0, '0);
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, tx_busy}, 32'd0);
    check("abort_count", 32'(fifo_count), 32'd0);
    check("abort_ready", {31'd0, data_ready}, 32'd1);
    low_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      step(0, 0, DB'($urandom));
      if (!tx || tx_busy) low_cnt++;
    end
    check("abort_no_frames", low_cnt, 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 799) == 0), ($urandom_range(0, 3) == 0), DB'($urandom));
    end
    for (int i = 0; i < 200; i++) step(0, 0, DB'($urandom));
    check("drain_busy", {31'd0, tx_busy}, 32'd0);
    check("drain_count", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
